// File: rtl/alu_ctl_pkg.sv
// Shared definitions for the sequenced LEGv8 ALU control unit: ALU control
// encodings, R-format opcodes, ALUOp classes and the sequencer state type.
package alu_ctl_pkg;

    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_OR      = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_LSL     = 4'b0011;
    localparam logic [3:0] CTRL_LSR     = 4'b0100;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_PASSB   = 4'b0111;
    localparam logic [3:0] CTRL_MUL     = 4'b1000;
    localparam logic [3:0] CTRL_UDIV    = 4'b1001;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_MUL  = 11'b10011011000;
    localparam logic [10:0] OP_UDIV = 11'b10011010110;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_OUT
    } state_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUOp/opcode decoder. UDIV is only recognised when the
// ALUCTL_DIV_EN macro is defined; otherwise it falls through to ILLEGAL.
module alu_ctl_decode
    import alu_ctl_pkg::*;
#(
    parameter int OPCODE_W = 11
) (
    input  logic [1:0]          alu_op,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [3:0]          ctrl,
    output logic                multi,
    output logic                is_div,
    output logic                illegal
);

    always_comb begin
        // NOTE: every output gets a value before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        ctrl    = CTRL_ADD;
        multi   = 1'b0;
        is_div  = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_MEM: ctrl = CTRL_ADD;
            ALUOP_CBZ: ctrl = CTRL_PASSB;
            ALUOP_IMM: begin
                case (opcode[9:8])
                    2'b00:   ctrl = CTRL_AND;
                    2'b01:   ctrl = CTRL_OR;
                    2'b10:   ctrl = CTRL_ADD;
                    default: ctrl = CTRL_SUB;
                endcase
            end
            default: begin
                case (opcode)
                    OPCODE_W'(OP_ADD): ctrl = CTRL_ADD;
                    OPCODE_W'(OP_SUB): ctrl = CTRL_SUB;
                    OPCODE_W'(OP_AND): ctrl = CTRL_AND;
                    OPCODE_W'(OP_ORR): ctrl = CTRL_OR;
                    OPCODE_W'(OP_LSL): ctrl = CTRL_LSL;
                    OPCODE_W'(OP_LSR): ctrl = CTRL_LSR;
                    OPCODE_W'(OP_MUL): begin
                        ctrl  = CTRL_MUL;
                        multi = 1'b1;
                    end
`ifdef ALUCTL_DIV_EN
                    OPCODE_W'(OP_UDIV): begin
                        ctrl   = CTRL_UDIV;
                        multi  = 1'b1;
                        is_div = 1'b1;
                    end
`endif
                    default: begin
                        ctrl    = CTRL_ILLEGAL;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Sequenced ALU control unit: registers the decoded control word, holds it
// through MUL/UDIV latency and hands it off with valid/ready. ALUCTL_DIV_EN enables UDIV.
module alu_control_seq
    import alu_ctl_pkg::*;
#(
    parameter int OPCODE_W = 11,
    parameter int CTRL_W   = 4,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 64
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                iValid,
    output logic                oReady,
    input  logic [OPCODE_W-1:0] iOpcode,
    input  logic [1:0]          iALUOp,
    output logic                oValid,
    input  logic                iReady,
    output logic [CTRL_W-1:0]   oControlSignal,
    output logic                oBusy,
    output logic                oIllegal
);

`ifdef ALUCTL_DIV_EN
    localparam int MAX_LAT  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int DIV_LOAD = DIV_LAT - 1;
`else
    localparam int MAX_LAT  = MUL_LAT;
    // DIV_LAT has no effect in this build; the divide load is never selected.
    localparam int DIV_LOAD = DIV_LAT - DIV_LAT;
`endif
    localparam int MUL_LOAD = MUL_LAT - 1;
    localparam int CNT_W    = $clog2(MAX_LAT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               illegal_q, illegal_d;
    logic               valid_q, busy_q;

    logic [3:0]         dec_ctrl;
    logic               dec_multi, dec_is_div, dec_illegal;
    logic               accept;

    alu_ctl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .alu_op  (iALUOp),
        .opcode  (iOpcode),
        .ctrl    (dec_ctrl),
        .multi   (dec_multi),
        .is_div  (dec_is_div),
        .illegal (dec_illegal)
    );

    assign oReady = (state_q == S_IDLE) || ((state_q == S_OUT) && iReady);
    assign accept = iValid && oReady;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        case (state_q)
            S_BUSY: begin
                if (cnt_q == '0) state_d = S_OUT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_OUT:   if (iReady) state_d = S_IDLE;
            default: ;
        endcase
        // A new request overrides the plain IDLE/OUT transitions above.
        if (accept) begin
            ctrl_d    = CTRL_W'(dec_ctrl);
            illegal_d = dec_illegal;
            if (dec_multi) begin
                state_d = S_BUSY;
                cnt_d   = dec_is_div ? CNT_W'(DIV_LOAD) : CNT_W'(MUL_LOAD);
            end else begin
                state_d = S_OUT;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // synchronous reset is sampled on the clock edge like any other input.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            valid_q   <= (state_d == S_OUT);
            busy_q    <= (state_d == S_BUSY);
        end
    end

    assign oValid         = valid_q;
    assign oBusy          = busy_q;
    assign oControlSignal = ctrl_q;
    assign oIllegal       = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: directed requests push expected words,
// a negedge monitor compares every presented result against the queue head.
module tb_alu_control_seq;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 64;

    logic        iCLK = 1'b0;
    logic        iRST_n, iValid, iReady;
    logic [10:0] iOpcode;
    logic [1:0]  iALUOp;
    logic        oReady, oValid, oBusy, oIllegal;
    logic [3:0]  oControlSignal;

    alu_control_seq #(
        .OPCODE_W (11),
        .CTRL_W   (4),
        .MUL_LAT  (MUL_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .iCLK           (iCLK),
        .iRST_n         (iRST_n),
        .iValid         (iValid),
        .oReady         (oReady),
        .iOpcode        (iOpcode),
        .iALUOp         (iALUOp),
        .oValid         (oValid),
        .iReady         (iReady),
        .oControlSignal (oControlSignal),
        .oBusy          (oBusy),
        .oIllegal       (oIllegal)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [3:0] ctrl;
        logic       ill;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   head_seen = 1'b0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle a result is presented it must match the queue head.
    always @(negedge iCLK) begin
        if (iRST_n === 1'b1 && oValid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got ctrl %0h with empty scoreboard (cycle %0d)",
                         oControlSignal, cyc);
            end else begin
                if (!head_seen) begin
                    check("latency_cycle", cyc, sb[0].due);
                    head_seen = 1'b1;
                end
                check("ctrl", {28'd0, oControlSignal}, {28'd0, sb[0].ctrl});
                check("illegal", {31'd0, oIllegal}, {31'd0, sb[0].ill});
                check("busy_with_valid", {31'd0, oBusy}, 32'd0);
                if (iReady) begin
                    void'(sb.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    // Present a request, wait for acceptance and record the expected result.
    // Accepted at the edge following this negedge; result due lat cycles later.
    task automatic issue(input logic [1:0] op, input logic [10:0] opc,
                         input logic [3:0] ctrl, input logic ill, input int lat);
        int t;
        iValid  = 1'b1;
        iALUOp  = op;
        iOpcode = opc;
        t = 0;
        @(negedge iCLK);
        while (!oReady && t < 200) begin
            @(negedge iCLK);
            t++;
        end
        if (!oReady) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got oReady 0 expected 1 after %0d cycles", t);
        end else begin
            sb.push_back('{ctrl, ill, cyc + 1 + lat});
        end
        @(posedge iCLK);
        #1;
        iValid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge iCLK);
            t++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"},    {28'd0, oControlSignal}, 32'd0);
        check({tag, "_valid"},   {31'd0, oValid},   32'd0);
        check({tag, "_busy"},    {31'd0, oBusy},    32'd0);
        check({tag, "_illegal"}, {31'd0, oIllegal}, 32'd0);
        check({tag, "_ready"},   {31'd0, oReady},   32'd1);
    endtask

    initial begin
        iRST_n  = 1'b0;
        iValid  = 1'b0;
        iReady  = 1'b1;
        iALUOp  = 2'b00;
        iOpcode = 11'd0;

        repeat (2) @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
        @(negedge iCLK);
        check_reset_outputs("por");
        @(posedge iCLK);
        #1;

        // R-type SUB: single-cycle, result one cycle after accept.
        issue(2'b10, 11'b11001011000, 4'b0110, 1'b0, 0);
        drain();

        // MUL: busy for MUL_LAT cycles, requests during busy are ignored.
        issue(2'b10, 11'b10011011000, 4'b1000, 1'b0, MUL_LAT);
        iValid  = 1'b1;
        iALUOp  = 2'b10;
        iOpcode = 11'b10001010000;
        for (int i = 0; i < MUL_LAT; i++) begin
            @(negedge iCLK);
            check("mul_busy",  {31'd0, oBusy},  32'd1);
            check("mul_ready", {31'd0, oReady}, 32'd0);
        end
        iValid = 1'b0;
        drain();
        @(negedge iCLK);
        check("mul_no_stray", {31'd0, oValid}, 32'd0);
        @(posedge iCLK);
        #1;

        // Immediate-class OR held by backpressure for three cycles.
        iReady = 1'b0;
        issue(2'b11, 11'b00100000000, 4'b0001, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check("hold_valid", {31'd0, oValid}, 32'd1);
            check("hold_ready", {31'd0, oReady}, 32'd0);
            @(posedge iCLK);
        end
        #1;
        iReady = 1'b1;
        drain();
        @(negedge iCLK);
        check("hold_released", {31'd0, oValid}, 32'd0);
        @(posedge iCLK);
        #1;

        // UDIV depends on the build configuration.
`ifdef ALUCTL_DIV_EN
        issue(2'b10, 11'b10011010110, 4'b1001, 1'b0, DIV_LAT);
`else
        issue(2'b10, 11'b10011010110, 4'b1111, 1'b1, 0);
`endif
        drain();

        // Back-to-back stream: one result per cycle.
        issue(2'b00, 11'b00000000000, 4'b0010, 1'b0, 0);
        issue(2'b01, 11'b11111111111, 4'b0111, 1'b0, 0);
        issue(2'b10, 11'b10001010000, 4'b0000, 1'b0, 0);
        issue(2'b10, 11'b10101010000, 4'b0001, 1'b0, 0);
        issue(2'b10, 11'b11010011011, 4'b0011, 1'b0, 0);
        issue(2'b10, 11'b11010011010, 4'b0100, 1'b0, 0);
        issue(2'b10, 11'b10001011000, 4'b0010, 1'b0, 0);
        issue(2'b10, 11'b11111111111, 4'b1111, 1'b1, 0);
        issue(2'b11, 11'b00000000000, 4'b0000, 1'b0, 0);
        issue(2'b11, 11'b01000000000, 4'b0010, 1'b0, 0);
        issue(2'b11, 11'b11100000000, 4'b0110, 1'b0, 0);
        drain();

        // Reset in the middle of a MUL aborts it without a result.
        issue(2'b10, 11'b10011011000, 4'b1000, 1'b0, MUL_LAT);
        @(negedge iCLK);
        check("pre_reset_busy", {31'd0, oBusy}, 32'd1);
        @(posedge iCLK);
        #1;
        iRST_n = 1'b0;
        sb.delete();
        head_seen = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
        @(negedge iCLK);
        check_reset_outputs("midrst");
        repeat (MUL_LAT + 2) begin
            @(negedge iCLK);
            check("post_reset_quiet", {31'd0, oValid}, 32'd0);
        end
        @(posedge iCLK);
        #1;

        // Unit still operational after the abort.
        issue(2'b01, 11'b00000000000, 4'b0111, 1'b0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised, sequenced ALU control unit for the LEGv8 datapath. Decodes the 11-bit opcode and the 2-bit ALUOp from the main control into a registered ALU control word. Adds a ready/valid handshake and an internal latency counter so multi-cycle operations (MUL, UDIV) hold the control word and report busy until done. Sits between the main control unit and the ALU/iterative multiply-divide unit.

## Interface
- OPCODE_W, 11, opcode field width
- CTRL_W, 4, ALU control word width
- MUL_LAT, 4, cycles a MUL occupies the unit (≥1)
- DIV_LAT, 64, cycles a UDIV occupies the unit (≥1)

- iCLK  in  1  clock, all state on rising edge
- iRST_n  in  1  synchronous, active-low reset
- iValid  in  1  request valid
- oReady  out  1  request accepted this cycle when iValid&oReady
- iOpcode  in  OPCODE_W  instruction opcode field
- iALUOp  in  2  ALUOp from main control
- oValid  out  1  control word complete
- iReady  in  1  consumer accepts oValid
- oControlSignal  out  CTRL_W  ALU control word
- oBusy  out  1  multi-cycle op in progress
- oIllegal  out  1  qualifies oValid: undecodable op

## Operation
- Encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, PASSB 0111, LSL 0011, LSR 0100, MUL 1000, UDIV 1001, ILLEGAL 1111.
- ALUOp 00 → ADD; 01 → PASSB; 11 → iOpcode[9:8]: 00 AND, 01 OR, 10 ADD, 11 SUB.
- ALUOp 10 → full opcode match: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 OR, 11010011011 LSL, 11010011010 LSR, 10011011000 MUL, 10011010110 UDIV; anything else ILLEGAL.
- FSM states IDLE, BUSY, OUT.
  - IDLE: oReady=1. Accept → decode and register; MUL/UDIV → BUSY, counter=LAT−1; otherwise → OUT.
  - BUSY: oBusy=1, oReady=0, oControlSignal held; counter decrements; at 0 → OUT.
  - OUT: oValid=1, outputs held until iReady. oReady=iReady. iReady without accept → IDLE; iReady with accept → decode new op as from IDLE.
- Illegal: → OUT with oControlSignal=1111, oIllegal=1; no BUSY phase.
- iValid while oReady=0 is ignored; upstream holds request.
- Counter width $clog2(max(MUL_LAT,DIV_LAT)+1); LAT=1 gives one BUSY cycle.

## Timing
- Reset (iRST_n=0 at edge): state IDLE, counter 0, oControlSignal 0000, oValid 0, oBusy 0, oIllegal 0. oReady is 1 from the first cycle after reset. Reset mid-BUSY/OUT aborts without completion.
- Single-cycle op accepted at edge N → oValid high from N+1.
- Multi-cycle op accepted at N → oBusy during N+1..N+LAT, oValid from N+LAT+1.
- Back-to-back with iReady=1 held: one result per cycle for single-cycle ops.
- All outputs registered except oReady, which is combinational from state and iReady.

## Configuration
- ALUCTL_DIV_EN defined: UDIV decoded, uses DIV_LAT.
- ALUCTL_DIV_EN undefined: UDIV opcode decodes as ILLEGAL; DIV_LAT unused. The counter is sized from MUL_LAT only.

## Structure
- Package alu_ctl_pkg: control-word localparams, opcode constants, FSM state enum.
- Sub-module alu_ctl_decode: combinational {iALUOp, iOpcode} → {control word, multi-cycle flag, illegal flag}. The ALUCTL_DIV_EN guard lives inside this sub-module.

## Test plan
- Reset low for 2 cycles mid-BUSY, then release → IDLE, all outputs 0, oReady=1 next cycle.
- ALUOp=10, opcode 11001011000, iReady=1 → oControlSignal=0110, oValid exactly 1 cycle after accept.
- ALUOp=10, opcode 10011011000, MUL_LAT=4 → oBusy for 4 cycles, then oValid with 1000; iValid ignored during BUSY.
- ALUOp=11, iOpcode[9:8]=01, iReady=0 for 3 cycles → 0001 held with oValid for 3 cycles; released on iReady.
- ALUOp=10, opcode 10011010110: with ALUCTL_DIV_EN, DIV_LAT=64 → oValid 65 cycles after accept with 1001; without the macro → 1111 and oIllegal after 1 cycle.
- Stream ALUOp 00, 01, 10/AND with iValid=iReady=1 → 0010, 0111, 0000 on consecutive cycles.
